// File: rtl/chord_sequencer_if.sv
// chord_sequencer_if: ROM, note-player and control bundle of the chord sequencer
interface chord_sequencer_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int NOTE_WIDTH = 6,
  parameter int DUR_WIDTH  = 6
);
  logic                            play;
  logic [ADDR_WIDTH-1:0]           rom_addr;
  logic [NOTE_WIDTH+DUR_WIDTH-1:0] rom_data;
  logic                            advance_done;
  logic [NOTE_WIDTH-1:0]           note1, note2, note3;
  logic [DUR_WIDTH-1:0]            duration1, duration2, duration3;
  logic                            new_note1, new_note2, new_note3;
  logic [DUR_WIDTH-1:0]            time_advance;
  logic                            time_advance_ready;
  logic                            song_done;
  modport master (
    input  play, rom_data, advance_done,
    output rom_addr, note1, note2, note3, duration1, duration2, duration3,
           new_note1, new_note2, new_note3, time_advance, time_advance_ready, song_done
  );
  modport slave (
    output play, rom_data, advance_done,
    input  rom_addr, note1, note2, note3, duration1, duration2, duration3,
           new_note1, new_note2, new_note3, time_advance, time_advance_ready, song_done
  );
endinterface

// File: rtl/chord_sequencer.sv
// chord_sequencer: refills expired voices from the song ROM and issues min-remaining time advances
module chord_sequencer #(
  parameter int ADDR_WIDTH = 10,
  parameter int NOTE_WIDTH = 6,
  parameter int DUR_WIDTH  = 6
) (
  input logic clk,
  input logic reset,
  chord_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, SEL, ADDR, LOAD, ADVANCE, WAIT, DONE} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NOTE_WIDTH-1:0] note_q [3], note_d [3];
  logic [DUR_WIDTH-1:0]  dur_q [3], dur_d [3], rem_q [3], rem_d [3];
  logic [DUR_WIDTH-1:0]  ta_q, ta_d, m01, rmin;
  logic [2:0]            nn_q, nn_d;
  logic [1:0]            sel_q, sel_d;
  logic                  rdy_q, rdy_d, done_q, done_d;
  logic [DUR_WIDTH-1:0]  fdur;
  logic [NOTE_WIDTH-1:0] fnote;
  assign fdur  = bus.rom_data[DUR_WIDTH-1:0];
  assign fnote = bus.rom_data[NOTE_WIDTH+DUR_WIDTH-1:DUR_WIDTH];
  assign m01   = rem_q[0] < rem_q[1] ? rem_q[0] : rem_q[1];
  assign rmin  = m01 < rem_q[2] ? m01 : rem_q[2];
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    note_d  = note_q;
    dur_d   = dur_q;
    rem_d   = rem_q;
    ta_d    = ta_q;
    nn_d    = '0;
    rdy_d   = 1'b0;
    done_d  = done_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: state_d = bus.play ? SEL : IDLE;
      SEL: if (bus.play) begin
        sel_d   = rem_q[0] == '0 ? 2'd0 : rem_q[1] == '0 ? 2'd1 : 2'd2;
        state_d = (rem_q[0] == '0 || rem_q[1] == '0 || rem_q[2] == '0) ? ADDR : ADVANCE;
      end
      ADDR: state_d = LOAD;
      LOAD: if (fdur == '0) begin
        done_d  = 1'b1;
        state_d = DONE;
      end else begin
        note_d[sel_q] = fnote;
        dur_d[sel_q]  = fdur;
        rem_d[sel_q]  = fdur;
        nn_d[sel_q]   = 1'b1;
        addr_d        = addr_q + 1'b1;
        done_d        = &addr_q;
        state_d       = &addr_q ? DONE : SEL;
      end
      ADVANCE: if (bus.play) begin
        ta_d    = rmin;
        rdy_d   = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (bus.advance_done) begin
        for (int i = 0; i < 3; i++) rem_d[i] = rem_q[i] - ta_q;
        state_d = SEL;
      end
      DONE: if (!bus.play) begin
        done_d  = 1'b0;
        addr_d  = '0;
        rem_d   = '{default: '0};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      note_q  <= '{default: '0};
      dur_q   <= '{default: '0};
      rem_q   <= '{default: '0};
      ta_q    <= '0;
      nn_q    <= '0;
      sel_q   <= '0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
      rem_q   <= rem_d;
      ta_q    <= ta_d;
      nn_q    <= nn_d;
      sel_q   <= sel_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
    end
  end
  assign bus.rom_addr           = addr_q;
  assign bus.note1              = note_q[0];
  assign bus.note2              = note_q[1];
  assign bus.note3              = note_q[2];
  assign bus.duration1          = dur_q[0];
  assign bus.duration2          = dur_q[1];
  assign bus.duration3          = dur_q[2];
  assign bus.new_note1          = nn_q[0];
  assign bus.new_note2          = nn_q[1];
  assign bus.new_note3          = nn_q[2];
  assign bus.time_advance       = ta_q;
  assign bus.time_advance_ready = rdy_q;
  assign bus.song_done          = done_q;
endmodule

// File: tb/tb_chord_sequencer.sv
// tb_chord_sequencer: cycle table for the reference song plus model-checked random songs
module tb_chord_sequencer;
  localparam int AW = 10, NW = 6, DW = 6;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  chord_sequencer_if #(.ADDR_WIDTH(AW), .NOTE_WIDTH(NW), .DUR_WIDTH(DW)) bus ();
  chord_sequencer #(.ADDR_WIDTH(AW), .NOTE_WIDTH(NW), .DUR_WIDTH(DW)) dut (.clk(clk), .reset(reset), .bus(bus));
  logic [NW+DW-1:0] rom [1024];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];
  typedef struct { logic play, adv; logic [2:0] nn; logic rdy; logic [DW-1:0] ta; logic [AW-1:0] addr; logic done; } vec_t;
  typedef struct { bit adv; int v, note, dur; } ev_t;
  vec_t tbl [27];
  ev_t  exp_q [$];
  int   exp_addr;
  int   checks = 0, errors = 0;
  function automatic vec_t v(int p, int a, int nn, int r, int ta, int ad, int d);
    vec_t x;
    x.play = p[0]; x.adv = a[0]; x.nn = nn[2:0]; x.rdy = r[0];
    x.ta = ta[DW-1:0]; x.addr = ad[AW-1:0]; x.done = d[0];
    return x;
  endfunction
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic int cur_note(int i);
    return i == 0 ? int'(bus.note1) : i == 1 ? int'(bus.note2) : int'(bus.note3);
  endfunction
  function automatic int cur_dur(int i);
    return i == 0 ? int'(bus.duration1) : i == 1 ? int'(bus.duration2) : int'(bus.duration3);
  endfunction
  // Event-level song walk: refill empty voices in priority order, then advance by the minimum.
  task automatic build_model();
    int rem [3] = '{0, 0, 0};
    int a = 0, m;
    bit fin = 0;
    exp_q.delete();
    while (!fin) begin
      for (int i = 0; i < 3; i++)
        if (!fin && rem[i] == 0) begin
          if (rom[a][DW-1:0] == 0) fin = 1;
          else begin
            exp_q.push_back('{0, i, int'(rom[a][NW+DW-1:DW]), int'(rom[a][DW-1:0])});
            rem[i] = rom[a][DW-1:0];
            a++;
            if (a == 1024) begin fin = 1; a = 0; end
          end
        end
      if (!fin) begin
        m = rem[0] < rem[1] ? rem[0] : rem[1];
        m = m < rem[2] ? m : rem[2];
        exp_q.push_back('{1, 0, 0, m});
        for (int i = 0; i < 3; i++) rem[i] -= m;
      end
    end
    exp_addr = a;
  endtask
  task automatic mon();
    logic [2:0] nn;
    ev_t e;
    int i;
    nn = {bus.new_note3, bus.new_note2, bus.new_note1};
    if (nn != 3'b000) begin
      chk("load_onehot", $countones(nn), 1);
      i = nn[0] ? 0 : nn[1] ? 1 : 2;
      if (exp_q.size() == 0) chk("unexpected_load", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("load_kind", 0, int'(e.adv));
        chk("load_voice", i, e.v);
        chk("load_note", cur_note(i), e.note);
        chk("load_dur", cur_dur(i), e.dur);
      end
    end
    if (bus.time_advance_ready) begin
      if (exp_q.size() == 0) chk("unexpected_advance", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("adv_kind", 1, int'(e.adv));
        chk("time_advance", int'(bus.time_advance), e.dur);
      end
    end
  endtask
  task automatic fill_random(int endpos, int maxdur);
    for (int i = 0; i < 1024; i++) rom[i] = {6'($urandom), 6'($urandom_range(maxdur, 1))};
    if (endpos >= 0) rom[endpos][DW-1:0] = '0;
  endtask
  task automatic run_song(int budget);
    int cyc = 0;
    build_model();
    while (!bus.song_done && cyc < budget) begin
      bus.advance_done = ($urandom % 4) == 0;
      bus.play = ($urandom % 8) != 0;
      tick();
      mon();
      cyc++;
    end
    chk("song_done_reached", int'(bus.song_done), 1);
    chk("events_left", exp_q.size(), 0);
    chk("end_addr", int'(bus.rom_addr), exp_addr);
    bus.play = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.advance_done = k[0];
      tick();
      mon();
    end
    chk("done_held", int'(bus.song_done), 1);
    bus.play = 1'b0;
    bus.advance_done = 1'b0;
    tick();
    chk("exit_done", int'(bus.song_done), 0);
    chk("exit_addr", int'(bus.rom_addr), 0);
  endtask
  initial begin
    int n;
    bus.play = 1'b0;
    bus.advance_done = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = '0;
    rom[0] = {6'd10, 6'd4}; rom[1] = {6'd20, 6'd2}; rom[2] = {6'd30, 6'd6};
    rom[3] = {6'd25, 6'd4}; rom[4] = {6'd0, 6'd0};
    tbl[0]  = v(1,0,0,0,0,0,0); tbl[1]  = v(1,1,0,0,0,0,0); tbl[2]  = v(1,1,0,0,0,0,0);
    tbl[3]  = v(1,1,1,0,0,1,0); tbl[4]  = v(1,0,0,0,0,1,0); tbl[5]  = v(1,0,0,0,0,1,0);
    tbl[6]  = v(1,0,2,0,0,2,0); tbl[7]  = v(1,0,0,0,0,2,0); tbl[8]  = v(1,0,0,0,0,2,0);
    tbl[9]  = v(1,0,4,0,0,3,0); tbl[10] = v(1,0,0,0,0,3,0); tbl[11] = v(1,0,0,1,2,3,0);
    tbl[12] = v(1,0,0,0,2,3,0); tbl[13] = v(1,1,0,0,2,3,0); tbl[14] = v(1,0,0,0,2,3,0);
    tbl[15] = v(1,0,0,0,2,3,0); tbl[16] = v(1,0,2,0,2,4,0); tbl[17] = v(1,0,0,0,2,4,0);
    tbl[18] = v(0,1,0,0,2,4,0); tbl[19] = v(0,0,0,0,2,4,0); tbl[20] = v(1,0,0,1,2,4,0);
    tbl[21] = v(1,1,0,0,2,4,0); tbl[22] = v(1,0,0,0,2,4,0); tbl[23] = v(1,0,0,0,2,4,0);
    tbl[24] = v(1,0,0,0,2,4,1); tbl[25] = v(1,1,0,0,2,4,1); tbl[26] = v(0,0,0,0,2,0,0);
    tick();
    tick();
    chk("rst_addr", int'(bus.rom_addr), 0);
    chk("rst_notes", int'(bus.note1) + int'(bus.note2) + int'(bus.note3), 0);
    chk("rst_durs", int'(bus.duration1) + int'(bus.duration2) + int'(bus.duration3), 0);
    chk("rst_ta", int'(bus.time_advance), 0);
    chk("rst_pulses", int'({bus.new_note1, bus.new_note2, bus.new_note3, bus.time_advance_ready}), 0);
    chk("rst_done", int'(bus.song_done), 0);
    reset = 1'b0;
    for (int r = 0; r < 27; r++) begin
      bus.play = tbl[r].play;
      bus.advance_done = tbl[r].adv;
      tick();
      chk($sformatf("t%0d_new_note", r), int'({bus.new_note3, bus.new_note2, bus.new_note1}), int'(tbl[r].nn));
      chk($sformatf("t%0d_ready", r), int'(bus.time_advance_ready), int'(tbl[r].rdy));
      chk($sformatf("t%0d_ta", r), int'(bus.time_advance), int'(tbl[r].ta));
      chk($sformatf("t%0d_addr", r), int'(bus.rom_addr), int'(tbl[r].addr));
      chk($sformatf("t%0d_done", r), int'(bus.song_done), int'(tbl[r].done));
      if (r == 9) begin
        chk("v1_note", int'(bus.note1), 10); chk("v1_dur", int'(bus.duration1), 4);
        chk("v2_note", int'(bus.note2), 20); chk("v2_dur", int'(bus.duration2), 2);
        chk("v3_note", int'(bus.note3), 30); chk("v3_dur", int'(bus.duration3), 6);
      end
    end
    chk("kept_note1", int'(bus.note1), 10);
    chk("kept_note2", int'(bus.note2), 25);
    chk("kept_dur2", int'(bus.duration2), 4);
    chk("kept_note3", int'(bus.note3), 30);
    for (int i = 0; i < 1024; i++) rom[i] = {6'(i), 6'd3};
    rom[9][DW-1:0] = '0;
    run_song(2000);
    for (int s = 0; s < 8; s++) begin
      fill_random(int'($urandom_range(60, 0)), int'($urandom_range(63, 1)));
      run_song(4000);
    end
    fill_random(-1, 3);
    run_song(40000);
    fill_random(-1, 8);
    bus.play = 1'b1;
    bus.advance_done = 1'b0;
    n = 0;
    while (!bus.time_advance_ready && n < 200) begin tick(); n++; end
    chk("reach_wait", int'(bus.time_advance_ready), 1);
    tick();
    reset = 1'b1;
    tick();
    chk("wrst_addr", int'(bus.rom_addr), 0);
    chk("wrst_notes", int'(bus.note1) + int'(bus.note2) + int'(bus.note3), 0);
    chk("wrst_durs", int'(bus.duration1) + int'(bus.duration2) + int'(bus.duration3), 0);
    chk("wrst_ta", int'(bus.time_advance), 0);
    chk("wrst_pulses", int'({bus.new_note1, bus.new_note2, bus.new_note3, bus.time_advance_ready}), 0);
    chk("wrst_done", int'(bus.song_done), 0);
    reset = 1'b0;
    bus.play = 1'b0;
    tick();
    fill_random(int'($urandom_range(40, 5)), 10);
    run_song(4000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
